// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: combinational hit path and a
// single-outstanding whole-line refill over a valid/ready request channel.
module icache_direct #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_valid_i,
    input  logic [31:0] read_address_i,
    output logic        read_ready_o,
    output logic [31:0] read_data_o,
    input  logic        flush_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_address_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = 32 - IB - OB - 2;
    localparam int LW = 32 - OB - 2;
    localparam logic [31:0]   NOP       = 32'h0000_0013;
    localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS - 1);
    localparam logic [OB-1:0] BEAT_ONE  = OB'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_REFILL  = 2'd2
    } state_t;

    state_t             state_r;
    logic [LINES-1:0]   valid_r;
    logic [TW-1:0]      tag_r  [LINES];
    logic [31:0]        data_r [LINES][WORDS];
    logic [LW-1:0]      miss_line_r;
    logic [OB-1:0]      count_r;
    logic               discard_r;

    logic [OB-1:0]      rd_word_s;
    logic [IB-1:0]      rd_index_s;
    logic [TW-1:0]      rd_tag_s;
    logic               hit_s;
    logic [IB-1:0]      fill_index_s;
    logic [TW-1:0]      fill_tag_s;
    logic               fill_beat_s;
    logic               last_beat_s;
    logic               unused_s;

    assign rd_word_s    = read_address_i[OB+1:2];
    assign rd_index_s   = read_address_i[IB+OB+1:OB+2];
    assign rd_tag_s     = read_address_i[31:IB+OB+2];
    assign fill_index_s = miss_line_r[IB-1:0];
    assign fill_tag_s   = miss_line_r[LW-1:IB];
    assign fill_beat_s  = (state_r == ST_REFILL) && mem_resp_valid_i;
    assign last_beat_s  = fill_beat_s && (count_r == LAST_BEAT);
    assign unused_s     = ^read_address_i[1:0];

    // Hit detection and read mux; a flush in the same cycle masks the hit.
    always_comb begin
        hit_s       = 1'b0;
        read_data_o = NOP;
        if (read_valid_i && (state_r == ST_IDLE) && !flush_i &&
            valid_r[rd_index_s] && (tag_r[rd_index_s] == rd_tag_s)) begin
            hit_s       = 1'b1;
            read_data_o = data_r[rd_index_s][rd_word_s];
        end else begin
            hit_s       = 1'b0;
            read_data_o = NOP;
        end
        read_ready_o = hit_s;
    end

    // Refill FSM with valid bits, discard flag and registered request outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r           <= ST_IDLE;
            valid_r           <= '0;
            miss_line_r       <= '0;
            count_r           <= '0;
            discard_r         <= 1'b0;
            mem_req_valid_o   <= 1'b0;
            mem_req_address_o <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    discard_r <= 1'b0;
                    if (flush_i) begin
                        valid_r <= '0;
                    end else if (read_valid_i && !hit_s) begin
                        miss_line_r       <= read_address_i[31:OB+2];
                        mem_req_address_o <= {read_address_i[31:OB+2], {(OB+2){1'b0}}};
                        mem_req_valid_o   <= 1'b1;
                        state_r           <= ST_REQUEST;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQUEST: begin
                    if (flush_i) begin
                        discard_r <= 1'b1;
                        valid_r   <= '0;
                    end
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        count_r         <= '0;
                        state_r         <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (flush_i) begin
                        discard_r <= 1'b1;
                        valid_r   <= '0;
                    end
                    if (mem_resp_valid_i) begin
                        count_r <= count_r + BEAT_ONE;
                        if (count_r == LAST_BEAT) begin
                            // A flush on the final beat must also keep the line invalid.
                            valid_r[fill_index_s] <= !(discard_r || flush_i);
                            discard_r             <= 1'b0;
                            state_r               <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    mem_req_valid_o <= 1'b0;
                end
            endcase
        end
    end

    // Line storage writes; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_beat_s) begin
            data_r[fill_index_s][count_r] <= mem_resp_data_i;
        end
        if (last_beat_s) begin
            tag_r[fill_index_s] <= fill_tag_s;
        end
    end

endmodule
